// File: rtl/wb_user_mailbox.sv
// Wishbone mailbox for the user address space: a host-to-user and a user-to-host
// FIFO of 32-bit words, with sticky overflow/underflow status and a level interrupt.
module wb_user_mailbox #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        u_h2u_valid_o,
    output logic [31:0] u_h2u_data_o,
    input  logic        u_h2u_ready_i,
    input  logic        u_u2h_valid_i,
    input  logic [31:0] u_u2h_data_i,
    output logic        u_u2h_ready_o,
    output logic        user_irq_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic        req;
    logic [1:0]  reg_sel;
    logic        wr_tx, rd_rx, wr_status, wr_irq_en;
    logic [31:0] tx_word;
    logic [31:0] rd_data;
    logic [31:0] status;
    logic        ovf, unf;
    logic [1:0]  irq_en;
    logic        unused_adr;

    logic [31:0]   h2u_mem [DEPTH];
    logic [PW-1:0] h2u_wr_ptr, h2u_rd_ptr;
    logic [CW-1:0] h2u_count;
    logic          h2u_empty, h2u_full, h2u_push, h2u_pop, ovf_set;

    logic [31:0]   u2h_mem [DEPTH];
    logic [PW-1:0] u2h_wr_ptr, u2h_rd_ptr;
    logic [CW-1:0] u2h_count;
    logic          u2h_empty, u2h_full, u2h_push, u2h_pop, unf_set;

    assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // The pending ack masks the request, so a held strobe yields one access per two cycles.
    assign req       = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign reg_sel   = wbs_adr_i[3:2];
    assign wr_tx     = req &&  wbs_we_i && (reg_sel == 2'd0);
    assign rd_rx     = req && !wbs_we_i && (reg_sel == 2'd1);
    assign wr_status = req &&  wbs_we_i && (reg_sel == 2'd2);
    assign wr_irq_en = req &&  wbs_we_i && (reg_sel == 2'd3) && wbs_sel_i[0];

    assign tx_word = {wbs_sel_i[3] ? wbs_dat_i[31:24] : 8'h00,
                      wbs_sel_i[2] ? wbs_dat_i[23:16] : 8'h00,
                      wbs_sel_i[1] ? wbs_dat_i[15:8]  : 8'h00,
                      wbs_sel_i[0] ? wbs_dat_i[7:0]   : 8'h00};

    assign h2u_empty = (h2u_count == '0);
    assign h2u_full  = (h2u_count == FULL_CNT);
    assign h2u_pop   = !h2u_empty && u_h2u_ready_i;
    // A same-edge user pop frees the slot, so a full FIFO still takes the push.
    assign h2u_push  = wr_tx && !(h2u_full && !h2u_pop);
    assign ovf_set   = wr_tx &&  (h2u_full && !h2u_pop);

    assign u2h_empty = (u2h_count == '0);
    assign u2h_full  = (u2h_count == FULL_CNT);
    assign u2h_push  = u_u2h_valid_i && !u2h_full;
    assign u2h_pop   = rd_rx && !u2h_empty;
    assign unf_set   = rd_rx &&  u2h_empty;

    assign u_h2u_valid_o = !h2u_empty;
    assign u_h2u_data_o  = h2u_empty ? 32'h0 : h2u_mem[h2u_rd_ptr];
    assign u_u2h_ready_o = !u2h_full;

    assign status = {8'h00, 8'(u2h_count), 8'(h2u_count), 2'b00,
                     unf, ovf, u2h_empty, u2h_full, h2u_empty, h2u_full};

    always_comb begin
        rd_data = 32'h0;
        if (!wbs_we_i) begin
            case (reg_sel)
                2'd1:    rd_data = u2h_empty ? 32'h0 : u2h_mem[u2h_rd_ptr];
                2'd2:    rd_data = status;
                2'd3:    rd_data = {30'h0, irq_en};
                default: rd_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (h2u_push) h2u_mem[h2u_wr_ptr] <= tx_word;
        if (u2h_push) u2h_mem[u2h_wr_ptr] <= u_u2h_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            h2u_wr_ptr <= '0;
            h2u_rd_ptr <= '0;
            h2u_count  <= '0;
            u2h_wr_ptr <= '0;
            u2h_rd_ptr <= '0;
            u2h_count  <= '0;
        end else begin
            if (h2u_push) h2u_wr_ptr <= h2u_wr_ptr + PW'(1);
            if (h2u_pop)  h2u_rd_ptr <= h2u_rd_ptr + PW'(1);
            if (h2u_push && !h2u_pop)      h2u_count <= h2u_count + CW'(1);
            else if (!h2u_push && h2u_pop) h2u_count <= h2u_count - CW'(1);
            if (u2h_push) u2h_wr_ptr <= u2h_wr_ptr + PW'(1);
            if (u2h_pop)  u2h_rd_ptr <= u2h_rd_ptr + PW'(1);
            if (u2h_push && !u2h_pop)      u2h_count <= u2h_count + CW'(1);
            else if (!u2h_push && u2h_pop) u2h_count <= u2h_count - CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'h0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            irq_en     <= 2'b00;
            user_irq_o <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rd_data : 32'h0;
            if (ovf_set)                        ovf <= 1'b1;
            else if (wr_status && wbs_dat_i[4]) ovf <= 1'b0;
            if (unf_set)                        unf <= 1'b1;
            else if (wr_status && wbs_dat_i[5]) unf <= 1'b0;
            if (wr_irq_en) irq_en <= wbs_dat_i[1:0];
            user_irq_o <= (irq_en[0] && !u2h_empty) || (irq_en[1] && h2u_empty);
        end
    end
endmodule

// File: tb/tb_wb_user_mailbox.sv
// Self-checking bench for wb_user_mailbox: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_wb_user_mailbox;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat_w = 32'h0;
    logic        ack, u_h2u_valid, u_u2h_ready, irq;
    logic [31:0] dat_r, u_h2u_data;
    logic        h2u_ready_drv = 1'b0, u2h_valid_drv = 1'b0, loop_en = 1'b0;
    logic [31:0] u2h_data_drv = 32'h0;
    logic        h2u_ready, u2h_valid;
    logic [31:0] u2h_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign h2u_ready = loop_en ? u_u2h_ready : h2u_ready_drv;
    assign u2h_valid = loop_en ? u_h2u_valid : u2h_valid_drv;
    assign u2h_data  = loop_en ? u_h2u_data  : u2h_data_drv;

    wb_user_mailbox #(.DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .u_h2u_valid_o(u_h2u_valid), .u_h2u_data_o(u_h2u_data), .u_h2u_ready_i(h2u_ready),
        .u_u2h_valid_i(u2h_valid), .u_u2h_data_i(u2h_data), .u_u2h_ready_o(u_u2h_ready),
        .user_irq_o(irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] h2u_q[$];
    logic [31:0] u2h_q[$];
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_ack = 1'b0, m_rd = 1'b0, m_irq = 1'b0;
    logic [1:0]  m_ie = 2'b00;
    logic [31:0] m_dat = 32'h0;

    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_status();
        int hs, us;
        hs = h2u_q.size();
        us = u2h_q.size();
        return 32'(hs == DEPTH) + 32'(hs == 0) * 2 + 32'(us == DEPTH) * 4 + 32'(us == 0) * 8
             + 32'(m_ovf) * 16 + 32'(m_unf) * 32 + 32'(hs) * 256 + 32'(us) * 65536;
    endfunction

    task automatic model_step();
        logic        req, h_ready, u_valid, h_pop, u_push, ovf_s, unf_s, nirq;
        logic [31:0] u_data, rv;
        int          a;
        h_ready = loop_en ? (u2h_q.size() < DEPTH) : h2u_ready_drv;
        u_valid = loop_en ? (h2u_q.size() > 0) : u2h_valid_drv;
        u_data  = loop_en ? ((h2u_q.size() > 0) ? h2u_q[0] : 32'h0) : u2h_data_drv;
        req = cyc && stb && !m_ack;
        a = int'(adr[3:2]);
        rv = 32'h0;
        if (req && !we) begin
            if (a == 1) rv = (u2h_q.size() > 0) ? u2h_q[0] : 32'h0;
            else if (a == 2) rv = model_status();
            else if (a == 3) rv = {30'h0, m_ie};
        end
        nirq   = (m_ie[0] && u2h_q.size() > 0) || (m_ie[1] && h2u_q.size() == 0);
        h_pop  = (h2u_q.size() > 0) && h_ready;
        u_push = u_valid && (u2h_q.size() < DEPTH);
        ovf_s = 1'b0;
        unf_s = 1'b0;
        if (req && we && a == 0) begin
            if (h2u_q.size() < DEPTH || h_pop) h2u_q.push_back(lane_mask(dat_w, sel));
            else ovf_s = 1'b1;
        end
        if (h_pop) void'(h2u_q.pop_front());
        if (req && !we && a == 1) begin
            if (u2h_q.size() > 0) void'(u2h_q.pop_front());
            else unf_s = 1'b1;
        end
        if (u_push) u2h_q.push_back(u_data);
        if (req && we && a == 2) begin
            if (dat_w[4]) m_ovf = 1'b0;
            if (dat_w[5]) m_unf = 1'b0;
        end
        if (ovf_s) m_ovf = 1'b1;
        if (unf_s) m_unf = 1'b1;
        if (req && we && a == 3 && sel[0]) m_ie = dat_w[1:0];
        m_ack = req;
        m_rd  = req && !we;
        m_dat = rv;
        m_irq = nirq;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                h2u_q.delete();
                u2h_q.delete();
                m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_rd = 1'b0;
                m_irq = 1'b0; m_ie = 2'b00; m_dat = 32'h0;
            end else begin
                model_step();
            end
        end
    end

    // Every cycle, compare all DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("ack", 32'(ack), 32'(m_ack));
            if (!m_ack || m_rd) check("dat_o", dat_r, m_dat);
            check("h2u_valid", 32'(u_h2u_valid), 32'(h2u_q.size() > 0));
            check("h2u_data", u_h2u_data, (h2u_q.size() > 0) ? h2u_q[0] : 32'h0);
            check("u2h_ready", 32'(u_u2h_ready), 32'(u2h_q.size() < DEPTH));
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic pop_with, output logic [31:0] rd);
        logic saved_ready;
        saved_ready = h2u_ready_drv;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, a, 2'b00}; dat_w = d; sel = s;
        if (pop_with) h2u_ready_drv = 1'b1;
        @(posedge clk); #1;
        if (pop_with) h2u_ready_drv = saved_ready;
        check("ack_latency", 32'(ack), 32'h1);
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_single", 32'(ack), 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, s, 1'b0, dummy);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, a, 32'h0, 4'hF, 1'b0, r);
        check(nm, r, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; loop_en = 1'b0;
        h2u_ready_drv = 1'b0; u2h_valid_drv = 1'b0; u2h_data_drv = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
        logic        chk_h;
        logic [31:0] exp_h;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] drain_exp [8];
    logic [31:0] r;

    initial begin
        tbl.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0000_000A, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd0, 32'hDEADBEEF, 4'h5, 32'h0,         1'b1, 32'h00AD00EF});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0000_0108, 1'b1, 32'h00AD00EF});
        tbl.push_back('{1'b0, 2'd0, 32'h0,        4'hF, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 32'h3,        4'h1, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0,        4'hF, 32'h3,         1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 32'h0,        4'hE, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0,        4'hF, 32'h3,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 32'h0,        4'hF, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0000_0128, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd2, 32'h20,       4'hF, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 32'h0,        4'hF, 32'h0000_0108, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd3, 32'h0,        4'h1, 32'h0,         1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 32'h0,        4'hF, 32'h0,         1'b0, 32'h0});

        // reset values
        #2;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_u2h_ready", 32'(u_u2h_ready), 32'h1);
        do_reset();

        // vector table
        foreach (tbl[i]) begin
            wb_access(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s, 1'b0, r);
            if (!tbl[i].we) check($sformatf("vec%0d_rdata", i), r, tbl[i].exp);
            if (tbl[i].chk_h) check($sformatf("vec%0d_h2u_data", i), u_h2u_data, tbl[i].exp_h);
        end

        // loopback through the user side
        do_reset();
        loop_en = 1'b1;
        for (int i = 1; i <= 8; i++) wr(2'd0, 32'hA5A5_0000 + 32'(i), 4'hF);
        repeat (2) @(posedge clk);
        #1 loop_en = 1'b0;
        for (int i = 1; i <= 8; i++) rd_chk($sformatf("loop_rx%0d", i), 2'd1, 32'hA5A5_0000 + 32'(i));
        rd_chk("loop_status", 2'd2, 32'h0000_000A);

        // overflow, W1C, and simultaneous push/pop while full
        do_reset();
        for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i), 4'hF);
        rd_chk("ovf_status", 2'd2, 32'h0000_0819);
        wr(2'd2, 32'h10, 4'hF);
        rd_chk("ovf_cleared", 2'd2, 32'h0000_0809);
        wb_access(1'b1, 2'd0, 32'hA, 4'hF, 1'b1, r);
        rd_chk("full_push_pop", 2'd2, 32'h0000_0809);
        drain_exp = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hA};
        h2u_ready_drv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), u_h2u_data, drain_exp[i]);
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(u_h2u_valid), 32'h0);
        h2u_ready_drv = 1'b0;

        // interrupt on U2H not empty
        do_reset();
        wr(2'd3, 32'h1, 4'h1);
        u2h_valid_drv = 1'b1; u2h_data_drv = 32'h1234_5678;
        @(posedge clk); #1;
        u2h_valid_drv = 1'b0;
        check("irq_push_edge", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'h1);
        rd_chk("irq_rx", 2'd1, 32'h1234_5678);
        check("irq_fall", 32'(irq), 32'h0);

        // interrupt on H2U empty
        do_reset();
        wr(2'd3, 32'h2, 4'h1);
        check("irq_h2u_empty", 32'(irq), 32'h1);

        // reset asserted on the edge a TXDATA request is sampled
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_w = 32'h55; sel = 4'hF;
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ack", 32'(ack), 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst_mid_status", 2'd2, 32'h0000_000A);

        // randomized traffic checked cycle by cycle against the model
        do_reset();
        repeat (600) begin
            int op;
            h2u_ready_drv = 1'($urandom_range(0, 1));
            u2h_valid_drv = 1'($urandom_range(0, 1));
            u2h_data_drv  = $urandom;
            op = $urandom_range(0, 7);
            case (op)
                0, 1: wb_access(1'b1, 2'd0, $urandom, 4'($urandom), 1'b0, r);
                2, 3: wb_access(1'b0, 2'd1, 32'h0, 4'hF, 1'b0, r);
                4:    wb_access(1'($urandom_range(0, 1)), 2'd2, $urandom, 4'hF, 1'b0, r);
                5:    wb_access(1'($urandom_range(0, 1)), 2'd3, $urandom, 4'($urandom), 1'b0, r);
                default: begin @(posedge clk); #1; end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_user_mailbox.md
# wb_user_mailbox

Wishbone slave that owns the user address space of the user project wrapper, i.e. every access not claimed by the debug registers. It provides two DEPTH-entry 32-bit FIFOs between the management SoC and user logic, plus status and a level-sensitive interrupt:

- **H2U:** host writes, user logic reads.
- **U2H:** user logic writes, host reads.

It sits directly downstream of the wrapper's address split, driven by the user-gated cycle signal. Its ack and read data feed the wrapper's return mux.

## Interface

Parameters:
- `DEPTH`, default 8: entries per FIFO. Must be a power of 2, range 2..128.
- `CW`, default $clog2(DEPTH)+1: occupancy counter width. Derived; do not override.

Ports (clock and reset first):
- `wb_clk_i`  in  1  Wishbone clock; the only clock.
- `wb_rst_ni`  in  1  reset, asynchronous and active-low. The wrapper drives it from ~wb_rst_i.
- `wbs_cyc_i`  in  1  cycle, already gated to the user space by the wrapper.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte lane selects.
- `wbs_adr_i`  in  32  address; only bits [3:2] are decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `u_h2u_valid_o`  out  1  H2U head entry valid.
- `u_h2u_data_o`  out  32  H2U head entry data.
- `u_h2u_ready_i`  in  1  user logic pops H2U when valid && ready.
- `u_u2h_valid_i`  in  1  user logic pushes U2H when valid && ready.
- `u_u2h_data_i`  in  32  U2H push data.
- `u_u2h_ready_o`  out  1  equals !u2h_full.
- `user_irq_o`  out  1  interrupt, registered, level-sensitive.

## Operation

Register map (offset = adr[3:2]*4):
- **0x0 TXDATA (W).** A write pushes the word into H2U. Bytes whose `wbs_sel_i` bit is 0 are written as 0x00. A read returns 0.
- **0x4 RXDATA (R).** A read pops the U2H head and returns it. If U2H is empty, the read returns 0 and sets UNF. A write is ignored but still acked.
- **0x8 STATUS.** Read fields:
  - [0] h2u_full
  - [1] h2u_empty
  - [2] u2h_full
  - [3] u2h_empty
  - [4] OVF (sticky)
  - [5] UNF (sticky)
  - [15:8] h2u_count, zero-extended
  - [23:16] u2h_count, zero-extended

  Writes: writing 1 to bit 4 or bit 5 clears that bit (W1C). All other bits are read-only.
- **0xC IRQ_EN (RW), bits [1:0].** Written only when sel[0]=1. Other bits read 0.

Wishbone and FIFO rules:
- A request is cyc && stb && !ack.
- A TXDATA write when H2U is full drops the data, sets OVF and is still acked.
- Every access is acked exactly once. There are no stalls and no error response.

Interrupt:
- `user_irq_o` is registered from (IRQ_EN[0] && !u2h_empty) || (IRQ_EN[1] && h2u_empty).

Simultaneous events:
- **H2U push (host) and pop (user) in the same edge:** both happen and the count is unchanged. When H2U is full, the push is still accepted because the pop frees an entry. Full is evaluated as count==DEPTH && !pop.
- **U2H push (user) and pop (host RXDATA) in the same edge:** both happen. If U2H is empty, the push lands and the pop returns 0 with UNF set; there is no fall-through.
- **OVF/UNF set and W1C clear in the same edge:** set wins.

Pointers and wrap-around:
- Each FIFO uses log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a CW-bit count.
- The count never exceeds DEPTH and never underflows.

## Timing

- **Request edge E:**
  - `wbs_ack_o` goes high for exactly one cycle after E.
  - `wbs_dat_o` is registered and valid in that same cycle.
  - `wbs_dat_o` is 0 whenever `wbs_ack_o` is low.
- **Access rate:** one access per 2 cycles at best. A master holding stb continuously sees one ack every other cycle.
- **Commit point:** pushes, pops, W1C and IRQ_EN writes all commit at E. STATUS read at E returns values from before E.
- **H2U latency:** a TXDATA push committed at E makes `u_h2u_valid_o` high in the cycle after E, i.e. the ack cycle.
- **U2H latency:** a user push at edge P is readable by an RXDATA request sampled at P+1 or later.
- **Interrupt latency:** `user_irq_o` lags the FIFO state by one cycle.
- **Reset values:**
  - Outputs: `wbs_ack_o`=0, `wbs_dat_o`=0, `u_h2u_valid_o`=0, `u_h2u_data_o`=0, `u_u2h_ready_o`=1, `user_irq_o`=0.
  - Internal state: pointers and counts 0, IRQ_EN 0, OVF 0, UNF 0.
- **Reset mid-access:** reset asserted mid-access clears all state immediately, including a pending ack. FIFO contents are lost. A request still present after reset deasserts is treated as new.

## Test plan

- **Loopback:** write 0xA5A5_0001..0xA5A5_0008 to TXDATA with user ready=1, and loop user output back into U2H. Then 8 RXDATA reads return the same sequence in order, and STATUS reads 0x0000_000A.
- **Overflow:** with user ready=0, make 9 TXDATA writes for DEPTH=8. Then STATUS[0]=1, OVF=1, h2u_count=8, and the 9th word is absent. Writing STATUS with 0x10 clears OVF only.
- **Underflow:** an RXDATA read with U2H empty returns 0x0000_0000, UNF=1, and the ack still arrives one cycle after the request.
- **Byte lanes:** a TXDATA write of 0xDEADBEEF with sel=4'b0101 makes `u_h2u_data_o` = 0x00AD00EF.
- **Interrupt:**
  - Set IRQ_EN=0b01, then have user logic push one word. `user_irq_o` rises one cycle after the push edge, and falls one cycle after the RXDATA pop.
  - With IRQ_EN=0b10 after reset, `user_irq_o`=1 because H2U is empty.
- **Reset and concurrency:**
  - Assert `wb_rst_ni`=0 on the cycle a TXDATA request is sampled. Then there is no ack, and counts read 0 after release.
  - Separately, with H2U full, do a simultaneous host push and user pop. The count stays 8 and OVF stays 0.
